prbs_checker_multi: RTL and testbench

Parametrised, self-synchronising PRBS checker: the next generation of the single-bit PRBS31 checker at the end of the BER chain (after grey decode, in parallel for DFE and MLSE paths). It accepts WIDTH bits per valid beat, supports PRBS7/15/23/31 at runtime, and acquires lock automatically. It counts bits and errors only while locked, detects loss of lock, and exposes saturating counters for BER readout.

---
 rtl/prbs_pkg.sv | 39 +++
 rtl/prbs_next_bits.sv | 30 +++
 rtl/prbs_checker_multi.sv | 210 +++++++++++++++++++++
 tb/tb_prbs_checker_multi.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types for the PRBS checker family: polynomial selector, tap table and
// checker FSM states.
package prbs_pkg;

  localparam int PRBS_MAX_ORDER = 31;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } poly_e;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Feedback taps (n, m): bit k = bit[k-n] ^ bit[k-m].
  typedef struct packed {
    logic [4:0] n;
    logic [4:0] m;
  } taps_t;

  function automatic taps_t poly_taps(input poly_e poly);
    taps_t taps;
    taps = '{n: 5'd31, m: 5'd28};
    case (poly)
      PRBS7:   taps = '{n: 5'd7,  m: 5'd6};
      PRBS15:  taps = '{n: 5'd15, m: 5'd14};
      PRBS23:  taps = '{n: 5'd23, m: 5'd18};
      PRBS31:  taps = '{n: 5'd31, m: 5'd28};
      default: taps = '{n: 5'd31, m: 5'd28};
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/prbs_next_bits.sv
// Predicts the next WIDTH PRBS bits from a 31-bit history (hist[0] = newest bit).
// Later bits chain on earlier predicted bits, so this doubles as a generator core.
module prbs_next_bits
  import prbs_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [PRBS_MAX_ORDER-1:0] hist,
  input  poly_e                     poly,
  output logic [WIDTH-1:0]          bits
);

  taps_t                     taps;
  logic [PRBS_MAX_ORDER-1:0] mask;
  logic [PRBS_MAX_ORDER-1:0] win;

  // Taps become a bit mask so the feedback is a masked parity, no variable index.
  always_comb begin
    taps = poly_taps(poly);
    mask = (PRBS_MAX_ORDER'(1) << (taps.n - 5'd1)) |
           (PRBS_MAX_ORDER'(1) << (taps.m - 5'd1));
    win  = hist;
    bits = '0;
    for (int k = 0; k < WIDTH; k++) begin
      bits[k] = ^(win & mask);
      win     = {win[PRBS_MAX_ORDER-2:0], bits[k]};
    end
  end

endmodule

// File: rtl/prbs_checker_multi.sv
// Self-synchronising multi-bit PRBS7/15/23/31 checker with automatic lock,
// loss-of-lock detection and saturating bit/error/lock-loss counters.
module prbs_checker_multi
  import prbs_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 48,
  parameter int LOCK_THRESH = 64,
  parameter int LOSS_WINDOW = 128,
  parameter int LOSS_THRESH = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   data_in_valid,
  input  logic [1:0]             poly_sel,
  input  logic                   clear,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] total_bits,
  output logic [COUNT_WIDTH-1:0] total_bit_errors,
  output logic [15:0]            lock_losses
);

  localparam int ERR_W  = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
  localparam int WCNT_W = $clog2(LOSS_WINDOW + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + WIDTH + 1);

  localparam logic [GOOD_W-1:0]    LOCK_THRESH_C = GOOD_W'(LOCK_THRESH);
  localparam logic [WCNT_W-1:0]    LOSS_WINDOW_C = WCNT_W'(LOSS_WINDOW);
  localparam logic [WERR_W-1:0]    LOSS_THRESH_C = WERR_W'(LOSS_THRESH);
  localparam logic [6:0]           WIDTH_FILL    = 7'(WIDTH);
  localparam logic [6:0]           ORDER_FILL    = 7'(PRBS_MAX_ORDER);
  localparam logic [COUNT_WIDTH:0] WIDTH_CNT     = (COUNT_WIDTH + 1)'(WIDTH);

  state_e state, state_next;
  poly_e  poly_q;

  logic [PRBS_MAX_ORDER-1:0] hist, hist_next;
  logic [5:0]                fill_cnt;
  logic [GOOD_W-1:0]         good_cnt;
  logic [WCNT_W-1:0]         win_cnt;
  logic [WERR_W-1:0]         win_err;

  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] shift_src;
  logic [ERR_W-1:0] beat_err;

  logic              poly_changed;
  logic              beat;
  logic [6:0]        fill_sum;
  logic              fill_done;
  logic [GOOD_W-1:0] good_inc;
  logic [WCNT_W-1:0] win_cnt_inc;
  logic              win_expired;
  logic [WERR_W-1:0] win_err_sum;
  logic              loss;

  logic locked_next;
  logic from_expected;
  logic count_en;
  logic lose_lock;

  logic [COUNT_WIDTH:0] bits_sum;
  logic [COUNT_WIDTH:0] errs_sum;
  logic [16:0]          losses_sum;

  prbs_next_bits #(.WIDTH(WIDTH)) u_next_bits (
    .hist (hist),
    .poly (poly_q),
    .bits (expected)
  );

  always_comb begin
    poly_changed = (poly_e'(poly_sel) != poly_q);
    beat         = data_in_valid && !poly_changed;
    beat_err     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      beat_err = beat_err + ERR_W'(data_in[k] ^ expected[k]);
    end
    fill_sum    = {1'b0, fill_cnt} + WIDTH_FILL;
    fill_done   = (fill_sum >= ORDER_FILL);
    good_inc    = good_cnt + 1'b1;
    win_cnt_inc = win_cnt + 1'b1;
    win_expired = (win_cnt_inc == LOSS_WINDOW_C);
    win_err_sum = win_err + WERR_W'(beat_err);
    loss        = (win_err_sum >= LOSS_THRESH_C);
    bits_sum    = {1'b0, total_bits} + WIDTH_CNT;
    errs_sum    = {1'b0, total_bit_errors} + (COUNT_WIDTH + 1)'(beat_err);
    losses_sum  = {1'b0, lock_losses} + 17'd1;
  end

  // While locked the history free-runs on predictions so line errors cannot propagate.
  always_comb begin
    shift_src = from_expected ? expected : data_in;
    hist_next = hist;
    for (int k = 0; k < WIDTH; k++) begin
      hist_next = {hist_next[PRBS_MAX_ORDER-2:0], shift_src[k]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (poly_changed) begin
      state_next = ST_HUNT;
    end else if (data_in_valid) begin
      case (state)
        ST_HUNT:   if (fill_done) state_next = ST_CHECK;
        ST_CHECK: begin
          if (beat_err != '0)              state_next = ST_HUNT;
          else if (good_inc == LOCK_THRESH_C) state_next = ST_LOCKED;
        end
        ST_LOCKED: if (loss) state_next = ST_HUNT;
        default:   state_next = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    locked_next   = (state_next == ST_LOCKED);
    from_expected = (state == ST_LOCKED);
    count_en      = beat && (state == ST_LOCKED) && !clear;
    lose_lock     = beat && (state == ST_LOCKED) && loss;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist     <= '0;
      poly_q   <= PRBS31;
      locked   <= 1'b0;
      fill_cnt <= '0;
      good_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
    end else begin
      poly_q <= poly_e'(poly_sel);
      locked <= locked_next;
      if (data_in_valid) hist <= hist_next;
      if (poly_changed) begin
        fill_cnt <= '0;
        good_cnt <= '0;
      end else if (data_in_valid) begin
        case (state)
          ST_HUNT: begin
            good_cnt <= '0;
            fill_cnt <= fill_done ? 6'd0 : fill_sum[5:0];
          end
          ST_CHECK: begin
            if (beat_err != '0) begin
              fill_cnt <= '0;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_THRESH_C) begin
                win_cnt <= '0;
                win_err <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (loss) begin
              fill_cnt <= '0;
              good_cnt <= '0;
            end else if (win_expired) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt_inc;
              win_err <= win_err_sum;
            end
          end
          default: begin
            fill_cnt <= '0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Clear outranks any increment in the same cycle; a carry out means hold at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total_bits       <= '0;
      total_bit_errors <= '0;
      lock_losses      <= '0;
    end else if (clear) begin
      total_bits       <= '0;
      total_bit_errors <= '0;
      lock_losses      <= '0;
    end else begin
      if (count_en) begin
        total_bits       <= bits_sum[COUNT_WIDTH] ? '1 : bits_sum[COUNT_WIDTH-1:0];
        total_bit_errors <= errs_sum[COUNT_WIDTH] ? '1 : errs_sum[COUNT_WIDTH-1:0];
      end
      if (lose_lock) begin
        lock_losses <= losses_sum[16] ? '1 : losses_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker_multi.sv
// Bench for prbs_checker_multi: a 1-bit/48-bit-counter instance and an
// 8-bit/8-bit-counter instance, checked against spec-derived expectations.
module tb_prbs_checker_multi;

  typedef struct {
    string  tag;
    bit     dut8;
    bit     lck;
    longint bits;
    longint errs;
    longint losses;
  } exp_t;

  typedef struct {
    int     beat;
    bit     lck;
    longint bits;
    longint errs;
    longint losses;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        data1, valid1, clear1;
  logic [1:0]  poly1;
  logic        locked1;
  logic [47:0] bits1, errs1;
  logic [15:0] loss1;
  logic [7:0]  data8;
  logic        valid8, clear8;
  logic [1:0]  poly8;
  logic        locked8;
  logic [7:0]  bits8, errs8;
  logic [15:0] loss8;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [30:0] g31;
  logic [6:0]  g7;

  prbs_checker_multi #(.WIDTH(1), .COUNT_WIDTH(48)) dut1 (
    .clk(clk), .rstn(rstn), .data_in(data1), .data_in_valid(valid1),
    .poly_sel(poly1), .clear(clear1), .locked(locked1), .total_bits(bits1),
    .total_bit_errors(errs1), .lock_losses(loss1)
  );

  prbs_checker_multi #(.WIDTH(8), .COUNT_WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .data_in(data8), .data_in_valid(valid8),
    .poly_sel(poly8), .clear(clear8), .locked(locked8), .total_bits(bits8),
    .total_bit_errors(errs8), .lock_losses(loss8)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Reference generators: polynomial definitions, newest bit at index 0.
  function automatic logic next31();
    logic b;
    b   = g31[30] ^ g31[27];
    g31 = {g31[29:0], b};
    return b;
  endfunction

  function automatic logic next7();
    logic b;
    b  = g7[6] ^ g7[5];
    g7 = {g7[5:0], b};
    return b;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit sel8, input logic [7:0] d, input logic v, input logic clr);
    @(negedge clk);
    if (sel8) begin
      data8 = d; valid8 = v; clear8 = clr;
    end else begin
      data1 = d[0]; valid1 = v; clear1 = clr;
    end
  endtask

  task automatic expect_out(input string tag, input bit sel8, input bit lck,
                            input longint b, input longint e, input longint l);
    exp_t x;
    x = '{tag, sel8, lck, b, e, l};
    sb.push_back(x);
  endtask

  task automatic check_output();
    exp_t x;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.dut8) begin
        cmp({x.tag, ".locked"}, 64'(locked8), 64'(x.lck));
        cmp({x.tag, ".bits"},   64'(bits8),   64'(x.bits));
        cmp({x.tag, ".errs"},   64'(errs8),   64'(x.errs));
        cmp({x.tag, ".losses"}, 64'(loss8),   64'(x.losses));
      end else begin
        cmp({x.tag, ".locked"}, 64'(locked1), 64'(x.lck));
        cmp({x.tag, ".bits"},   64'(bits1),   64'(x.bits));
        cmp({x.tag, ".errs"},   64'(errs1),   64'(x.errs));
        cmp({x.tag, ".losses"}, 64'(loss1),   64'(x.losses));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, ".locked1"}, 64'(locked1), 64'd0);
    cmp({tag, ".bits1"},   64'(bits1),   64'd0);
    cmp({tag, ".errs1"},   64'(errs1),   64'd0);
    cmp({tag, ".losses1"}, 64'(loss1),   64'd0);
    cmp({tag, ".locked8"}, 64'(locked8), 64'd0);
    cmp({tag, ".bits8"},   64'(bits8),   64'd0);
    cmp({tag, ".errs8"},   64'(errs8),   64'd0);
    cmp({tag, ".losses8"}, 64'(loss8),   64'd0);
  endtask

  initial begin
    logic       b;
    logic [7:0] d;

    vecs = '{'{1, 0, 0, 0, 0}, '{31, 0, 0, 0, 0}, '{94, 0, 0, 0, 0},
             '{95, 1, 0, 0, 0}, '{96, 1, 1, 0, 0}, '{1000, 1, 905, 0, 0},
             '{10000, 1, 9905, 0, 0}};
    rstn = 1'b1;
    data1 = 1'b0; valid1 = 1'b0; clear1 = 1'b0; poly1 = 2'd3;
    data8 = 8'h00; valid8 = 1'b0; clear8 = 1'b0; poly8 = 2'd0;
    g31 = '1;
    g7  = '1;
    #1 rstn = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 8'h00, 1'b0, 1'b0);
      check_output();
    end

    $display("[TB] PRBS31 clean stream, WIDTH=1");
    for (int beat_n = 1, ti = 0; beat_n <= 10000; beat_n++) begin
      b = next31();
      apply_stimulus(0, {7'b0, b}, 1'b1, 1'b0);
      if (ti < 7 && vecs[ti].beat == beat_n) begin
        expect_out($sformatf("prbs31_beat%0d", beat_n), 0, vecs[ti].lck,
                   vecs[ti].bits, vecs[ti].errs, vecs[ti].losses);
        ti++;
      end
      check_output();
    end

    $display("[TB] Inject 32 errors, expect loss of lock then relock");
    for (int i = 1; i <= 32; i++) begin
      b = next31();
      apply_stimulus(0, {7'b0, ~b}, 1'b1, 1'b0);
      if (i == 31) expect_out("err31", 0, 1, 9936, 31, 0);
      if (i == 32) expect_out("err32_loss", 0, 0, 9937, 32, 1);
      check_output();
    end
    for (int r = 1; r <= 96; r++) begin
      b = next31();
      apply_stimulus(0, {7'b0, b}, 1'b1, 1'b0);
      if (r == 94) expect_out("relock94", 0, 0, 9937, 32, 1);
      if (r == 95) expect_out("relock95", 0, 1, 9937, 32, 1);
      if (r == 96) expect_out("relock96", 0, 1, 9938, 32, 1);
      check_output();
    end

    $display("[TB] Switch to PRBS7 while locked");
    apply_stimulus(0, 8'h00, 1'b0, 1'b0);
    poly1 = 2'd0;
    expect_out("poly_change", 0, 0, 9938, 32, 1);
    check_output();
    g7 = '1;
    for (int p = 1; p <= 96; p++) begin
      b = next7();
      apply_stimulus(0, {7'b0, b}, 1'b1, 1'b0);
      if (p == 94) expect_out("prbs7_94", 0, 0, 9938, 32, 1);
      if (p == 95) expect_out("prbs7_95", 0, 1, 9938, 32, 1);
      if (p == 96) expect_out("prbs7_96", 0, 1, 9939, 32, 1);
      check_output();
    end

    $display("[TB] Asynchronous reset mid-stream");
    #2 rstn = 1'b0;
    valid1 = 1'b0;
    #1 check_all_zero("async_reset");
    poly1 = 2'd3;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 8'h00, 1'b0, 1'b0);
      check_output();
    end
    for (int r = 1; r <= 96; r++) begin
      b = next31();
      apply_stimulus(0, {7'b0, b}, 1'b1, 1'b0);
      if (r == 94) expect_out("post_rst94", 0, 0, 0, 0, 0);
      if (r == 95) expect_out("post_rst95", 0, 1, 0, 0, 0);
      if (r == 96) expect_out("post_rst96", 0, 1, 1, 0, 0);
      check_output();
    end
    apply_stimulus(0, 8'h00, 1'b0, 1'b0);

    $display("[TB] WIDTH=8 PRBS7: single error, saturation, clear");
    g7 = '1;
    for (int beat_n = 1; beat_n <= 112; beat_n++) begin
      for (int i = 0; i < 8; i++) d[i] = next7();
      if (beat_n == 70)  d[3] = ~d[3];
      if (beat_n == 111) d = d ^ 8'h22;
      apply_stimulus(1, d, 1'b1, beat_n == 111);
      case (beat_n)
        67:      expect_out("w8_b67", 1, 0, 0, 0, 0);
        68:      expect_out("w8_lock", 1, 1, 0, 0, 0);
        69:      expect_out("w8_b69", 1, 1, 8, 0, 0);
        70:      expect_out("w8_err", 1, 1, 16, 1, 0);
        71:      expect_out("w8_after_err", 1, 1, 24, 1, 0);
        99:      expect_out("w8_b99", 1, 1, 248, 1, 0);
        100:     expect_out("w8_sat", 1, 1, 255, 1, 0);
        110:     expect_out("w8_sat_hold", 1, 1, 255, 1, 0);
        111:     expect_out("w8_clear", 1, 1, 0, 0, 0);
        112:     expect_out("w8_after_clear", 1, 1, 8, 0, 0);
        default: ;
      endcase
      check_output();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
